// File: rtl/fwd_unit_multi.sv
// EX-stage operand forwarding and load-use interlock for an N-wide in-order pipeline.
// A private shadow pipeline of LOAD_LAT+1 stages tracks in-flight writebacks.
module fwd_unit_multi #(
    parameter int NUM_SLOTS = 2,
    parameter int XLEN      = 32,
    parameter int RA_W      = 5,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SLOTS-1:0]      ex_valid,
    input  logic [NUM_SLOTS-1:0]      ex_rd_we,
    input  logic [NUM_SLOTS-1:0]      ex_is_load,
    input  logic [NUM_SLOTS*RA_W-1:0] ex_rd_addr,
    input  logic [NUM_SLOTS*XLEN-1:0] ex_data,
    input  logic [NUM_SLOTS*RA_W-1:0] ex_rs1_addr,
    input  logic [NUM_SLOTS*RA_W-1:0] ex_rs2_addr,
    input  logic [NUM_SLOTS*XLEN-1:0] rf_rs1_data,
    input  logic [NUM_SLOTS*XLEN-1:0] rf_rs2_data,
    input  logic [XLEN-1:0]           ld_rsp_data,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      cnt_clr,
    output logic [NUM_SLOTS*XLEN-1:0] fwd_rs1_data,
    output logic [NUM_SLOTS*XLEN-1:0] fwd_rs2_data,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int D = LOAD_LAT + 1;

    // Shadow stage k (1..D) holds one writeback entry per issue slot.
    logic [NUM_SLOTS-1:0] st_v   [1:D];
    logic [NUM_SLOTS-1:0] st_ld  [1:D];
    logic [NUM_SLOTS-1:0] st_rdy [1:D];
    logic [RA_W-1:0]      st_rd  [1:D][NUM_SLOTS];
    logic [XLEN-1:0]      st_data[1:D][NUM_SLOTS];

    logic                 wait_any;
    logic [NUM_SLOTS-1:0] ex_wr;

    always_comb begin
        ex_wr = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ex_wr[i] = ex_valid[i] & ex_rd_we[i] & (ex_rd_addr[i*RA_W +: RA_W] != '0);
        end
    end

    // Producer search: scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [RA_W-1:0] rs;
        logic [XLEN-1:0] val;
        logic            wt;
        fwd_rs1_data = rf_rs1_data;
        fwd_rs2_data = rf_rs2_data;
        wait_any     = 1'b0;
        for (int op = 0; op < 2; op++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                rs  = (op == 0) ? ex_rs1_addr[j*RA_W +: RA_W] : ex_rs2_addr[j*RA_W +: RA_W];
                val = (op == 0) ? rf_rs1_data[j*XLEN +: XLEN] : rf_rs2_data[j*XLEN +: XLEN];
                wt  = 1'b0;
                if (ex_valid[j] && (rs != '0)) begin
                    for (int k = D; k >= 1; k--) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (st_v[k][i] && (st_rd[k][i] == rs)) begin
                                if (!st_rdy[k][i] && (k == LOAD_LAT)) begin
                                    val = ld_rsp_data;
                                end else begin
                                    val = st_data[k][i];
                                end
                                wt = !st_rdy[k][i] && (k < LOAD_LAT);
                            end
                        end
                    end
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if ((i < j) && ex_valid[i] && ex_rd_we[i] &&
                            (ex_rd_addr[i*RA_W +: RA_W] == rs)) begin
                            val = ex_data[i*XLEN +: XLEN];
                            wt  = ex_is_load[i];
                        end
                    end
                end
                if (op == 0) begin
                    fwd_rs1_data[j*XLEN +: XLEN] = val;
                end else begin
                    fwd_rs2_data[j*XLEN +: XLEN] = val;
                end
                wait_any = wait_any | wt;
            end
        end
    end

    assign stall = !flush && wait_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= D; k++) begin
                st_v[k]   <= '0;
                st_ld[k]  <= '0;
                st_rdy[k] <= '0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    st_rd[k][i]   <= '0;
                    st_data[k][i] <= '0;
                end
            end
        end else if (flush) begin
            for (int k = 1; k <= D; k++) begin
                st_v[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = D; k >= 2; k--) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    st_v[k][i]  <= st_v[k-1][i];
                    st_ld[k][i] <= st_ld[k-1][i];
                    st_rd[k][i] <= st_rd[k-1][i];
                    // A load leaving stage LOAD_LAT latches its returning data.
                    if ((k - 1 == LOAD_LAT) && st_ld[k-1][i] && !st_rdy[k-1][i]) begin
                        st_rdy[k][i]  <= 1'b1;
                        st_data[k][i] <= ld_rsp_data;
                    end else begin
                        st_rdy[k][i]  <= st_rdy[k-1][i];
                        st_data[k][i] <= st_data[k-1][i];
                    end
                end
            end
            st_v[1]   <= stall ? '0 : ex_wr;
            st_ld[1]  <= ex_is_load;
            st_rdy[1] <= ~ex_is_load;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                st_rd[1][i]   <= ex_rd_addr[i*RA_W +: RA_W];
                st_data[1][i] <= ex_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall && !hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_unit_multi.sv
// Bench for fwd_unit_multi: directed scenarios plus random bundles, checked against
// an age-ordered list model of in-flight writebacks through an expected-value queue.
module tb_fwd_unit_multi;

    localparam int NS   = 4;
    localparam int XL   = 32;
    localparam int RAW  = 5;
    localparam int LL   = 2;
    localparam int CW   = 4;
    localparam int D    = LL + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     ex_valid, ex_rd_we, ex_is_load;
    logic [NS*RAW-1:0] ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic [NS*XL-1:0]  ex_data, rf_rs1_data, rf_rs2_data;
    logic [XL-1:0]     ld_rsp_data;
    logic              hold, flush, cnt_clr;
    logic [NS*XL-1:0]  fwd_rs1_data, fwd_rs2_data;
    logic              stall;
    logic [CW-1:0]     stall_cnt;

    fwd_unit_multi #(.NUM_SLOTS(NS), .XLEN(XL), .RA_W(RAW), .LOAD_LAT(LL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_data(ex_data),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .ld_rsp_data(ld_rsp_data),
        .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each record is one in-flight writeback; age = edges advanced since it left EX.
    typedef struct {
        int          slot;
        int          age;
        logic [RAW-1:0] rd;
        bit          is_ld;
        bit          rdy;
        logic [XL-1:0] data;
    } rec_t;

    typedef struct packed {
        logic          stall;
        logic [CW-1:0] cnt;
        logic [NS-1:0] m1;
        logic [NS-1:0] m2;
        logic [NS*XL-1:0] v1;
        logic [NS*XL-1:0] v2;
    } exp_t;

    rec_t hist[$];
    exp_t exp_q[$];
    int   m_cnt;
    bit   last_stall;
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void resolve(input int j, input logic [RAW-1:0] rs, input logic [XL-1:0] rf,
                                    output logic [XL-1:0] val, output bit known, output bit wt);
        int best;
        val = rf;
        known = 1'b1;
        wt = 1'b0;
        if (!ex_valid[j] || rs == '0) return;
        for (int i = j - 1; i >= 0; i--) begin
            if (ex_valid[i] && ex_rd_we[i] && ex_rd_addr[i*RAW +: RAW] == rs) begin
                if (ex_is_load[i]) begin
                    known = 1'b0;
                    wt = 1'b1;
                end else begin
                    val = ex_data[i*XL +: XL];
                end
                return;
            end
        end
        best = -1;
        for (int n = 0; n < hist.size(); n++) begin
            if (hist[n].rd == rs) begin
                if (best < 0 || hist[n].age < hist[best].age ||
                    (hist[n].age == hist[best].age && hist[n].slot > hist[best].slot)) best = n;
            end
        end
        if (best >= 0) begin
            if (hist[best].rdy) val = hist[best].data;
            else if (hist[best].age == LL) val = ld_rsp_data;
            else begin
                known = 1'b0;
                wt = 1'b1;
            end
        end
    endfunction

    // Apply one clock edge to the model using the inputs held during the ending cycle.
    function automatic void model_edge();
        rec_t keep_q[$];
        rec_t r;
        if (cnt_clr) m_cnt = 0;
        else if (last_stall && !hold && m_cnt < CMAX) m_cnt++;
        if (flush) begin
            hist.delete();
        end else if (!hold) begin
            foreach (hist[n]) begin
                r = hist[n];
                if (r.is_ld && !r.rdy && r.age == LL) begin
                    r.data = ld_rsp_data;
                    r.rdy = 1'b1;
                end
                r.age++;
                if (r.age <= D) keep_q.push_back(r);
            end
            hist = keep_q;
            if (!last_stall) begin
                for (int i = 0; i < NS; i++) begin
                    if (ex_valid[i] && ex_rd_we[i] && ex_rd_addr[i*RAW +: RAW] != '0) begin
                        r.slot = i;
                        r.age = 1;
                        r.rd = ex_rd_addr[i*RAW +: RAW];
                        r.is_ld = ex_is_load[i];
                        r.rdy = !ex_is_load[i];
                        r.data = ex_data[i*XL +: XL];
                        hist.push_back(r);
                    end
                end
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue();
        exp_t e;
        logic [XL-1:0] v;
        bit kn, wt, any;
        any = 1'b0;
        e = '0;
        for (int j = 0; j < NS; j++) begin
            resolve(j, ex_rs1_addr[j*RAW +: RAW], rf_rs1_data[j*XL +: XL], v, kn, wt);
            e.v1[j*XL +: XL] = v;
            e.m1[j] = kn;
            any = any | wt;
            resolve(j, ex_rs2_addr[j*RAW +: RAW], rf_rs2_data[j*XL +: XL], v, kn, wt);
            e.v2[j*XL +: XL] = v;
            e.m2[j] = kn;
            any = any | wt;
        end
        e.stall = !flush && any;
        e.cnt = m_cnt[CW-1:0];
        last_stall = e.stall;
        exp_q.push_back(e);
    endtask

    task automatic clear_bundle();
        ex_valid = '0;
        ex_rd_we = '0;
        ex_is_load = '0;
        ex_rd_addr = '0;
        ex_rs1_addr = '0;
        ex_rs2_addr = '0;
        ex_data = '0;
        hold = 1'b0;
        flush = 1'b0;
        cnt_clr = 1'b0;
        for (int i = 0; i < NS; i++) begin
            rf_rs1_data[i*XL +: XL] = 32'h11;
            rf_rs2_data[i*XL +: XL] = 32'h22;
        end
    endtask

    task automatic set_slot(input int i, input bit we, input bit ld, input int rd,
                            input int rs1, input int rs2, input logic [XL-1:0] data);
        ex_valid[i] = 1'b1;
        ex_rd_we[i] = we;
        ex_is_load[i] = ld;
        ex_rd_addr[i*RAW +: RAW] = RAW'(rd);
        ex_rs1_addr[i*RAW +: RAW] = RAW'(rs1);
        ex_rs2_addr[i*RAW +: RAW] = RAW'(rs2);
        ex_data[i*XL +: XL] = data;
    endtask

    task automatic flush_cycle();
        tick();
        clear_bundle();
        flush = 1'b1;
        issue();
    endtask

    // Keep the current bundle in EX until the model says the stall has cleared.
    task automatic run_out_stall();
        for (int n = 0; n < 6 && last_stall; n++) begin
            tick();
            hold = 1'b0;
            flush = 1'b0;
            ld_rsp_data = $urandom;
            issue();
        end
    endtask

    task automatic rand_bundle();
        ex_is_load = '0;
        for (int i = 0; i < NS; i++) begin
            ex_valid[i] = ($urandom_range(0, 9) < 8);
            ex_rd_we[i] = ($urandom_range(0, 9) < 8);
            ex_rd_addr[i*RAW +: RAW] = RAW'($urandom_range(0, 7));
            ex_rs1_addr[i*RAW +: RAW] = RAW'($urandom_range(0, 7));
            ex_rs2_addr[i*RAW +: RAW] = RAW'($urandom_range(0, 7));
            ex_data[i*XL +: XL] = $urandom;
        end
        if ($urandom_range(0, 9) < 3) ex_is_load[$urandom_range(0, NS - 1)] = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", 64'(stall), 64'(e.stall));
                chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
                for (int j = 0; j < NS; j++) begin
                    if (e.m1[j]) chk($sformatf("fwd_rs1[%0d]", j), 64'(fwd_rs1_data[j*XL +: XL]), 64'(e.v1[j*XL +: XL]));
                    if (e.m2[j]) chk($sformatf("fwd_rs2[%0d]", j), 64'(fwd_rs2_data[j*XL +: XL]), 64'(e.v2[j*XL +: XL]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit keep;
        checks = 0;
        failures = 0;
        m_cnt = 0;
        last_stall = 1'b0;
        rst_n = 1'b0;
        ld_rsp_data = '0;
        clear_bundle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset and idle: valid consumers with no producer anywhere.
        tick();
        clear_bundle();
        for (int i = 0; i < NS; i++) set_slot(i, 1'b0, 1'b0, 0, i + 1, i + 2, '0);
        issue();

        // Intra-bundle forward, then rd = x0.
        flush_cycle();
        tick();
        clear_bundle();
        set_slot(0, 1'b1, 1'b0, 5, 0, 0, 32'h1234);
        set_slot(1, 1'b0, 1'b0, 0, 5, 0, '0);
        issue();
        flush_cycle();
        tick();
        clear_bundle();
        set_slot(0, 1'b1, 1'b0, 0, 0, 0, 32'h1234);
        set_slot(1, 1'b0, 1'b0, 0, 0, 0, '0);
        issue();

        // Same-bundle load-use.
        flush_cycle();
        tick();
        clear_bundle();
        set_slot(0, 1'b1, 1'b1, 7, 0, 0, '0);
        set_slot(1, 1'b0, 1'b0, 0, 0, 7, '0);
        issue();
        run_out_stall();

        // Load r9 in slot 2, consumer in slot 0 of the next bundle, then trailing reads.
        flush_cycle();
        tick();
        clear_bundle();
        set_slot(2, 1'b1, 1'b1, 9, 0, 0, '0);
        issue();
        tick();
        clear_bundle();
        set_slot(0, 1'b0, 1'b0, 0, 9, 0, '0);
        issue();
        run_out_stall();
        tick();
        ld_rsp_data = 32'hBEEF;
        issue();

        // Priority chain across S2, S1 and EX.
        flush_cycle();
        for (int n = 0; n < 3; n++) begin
            tick();
            clear_bundle();
            set_slot(0, 1'b1, 1'b0, 3, 0, 0, 32'hA + n);
            set_slot(1, 1'b0, 1'b0, 0, 3, 3, '0);
            issue();
        end
        // Younger ALU write shadows an unready load.
        tick();
        clear_bundle();
        set_slot(0, 1'b1, 1'b1, 4, 0, 0, '0);
        set_slot(1, 1'b1, 1'b0, 4, 0, 0, 32'h44);
        set_slot(2, 1'b0, 1'b0, 0, 4, 4, '0);
        issue();

        // Hold during a stall, then release.
        flush_cycle();
        tick();
        clear_bundle();
        set_slot(1, 1'b1, 1'b1, 6, 0, 0, '0);
        set_slot(3, 1'b0, 1'b0, 0, 6, 0, '0);
        issue();
        for (int n = 0; n < 2; n++) begin
            tick();
            hold = 1'b1;
            issue();
        end
        run_out_stall();

        // Flush during a cross-bundle stall.
        flush_cycle();
        tick();
        clear_bundle();
        set_slot(0, 1'b1, 1'b1, 9, 0, 0, '0);
        issue();
        tick();
        clear_bundle();
        set_slot(0, 1'b0, 1'b0, 0, 9, 0, '0);
        issue();
        tick();
        flush = 1'b1;
        issue();
        tick();
        flush = 1'b0;
        issue();

        // Asynchronous reset while a stall is showing.
        tick();
        clear_bundle();
        set_slot(0, 1'b1, 1'b1, 7, 0, 0, '0);
        set_slot(1, 1'b0, 1'b0, 0, 0, 7, '0);
        issue();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_bundle();
        set_slot(0, 1'b1, 1'b1, 7, 0, 0, '0);
        set_slot(1, 1'b0, 1'b0, 0, 0, 7, '0);
        ex_valid = '0;
        #1;
        chk("async_rst_stall", 64'(stall), 64'(0));
        chk("async_rst_cnt", 64'(stall_cnt), 64'(0));
        hist.delete();
        m_cnt = 0;
        last_stall = 1'b0;
        #1;
        rst_n = 1'b1;

        // Random bundles; a stalled or held bundle stays in EX.
        for (int c = 0; c < 1500; c++) begin
            tick();
            keep = (last_stall || hold) && !flush;
            if (!keep) rand_bundle();
            for (int i = 0; i < NS; i++) begin
                rf_rs1_data[i*XL +: XL] = $urandom;
                rf_rs2_data[i*XL +: XL] = $urandom;
            end
            ld_rsp_data = $urandom;
            hold = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            issue();
        end

        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
